reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard with saturating counters and a sticky error flag.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle final commit unblock stall.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [1:0] issue_reg,
    input  logic       commit_valid,
    input  logic [1:0] commit_reg,
    input  logic       kill_valid,
    input  logic [1:0] kill_reg,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [1:0] rs_addr,
    input  logic [1:0] rt_addr,
    output logic       stall,
    output logic [3:0] busy,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic             err_q;
    logic             err_d;
    logic [3:0]       stall_mask;
    logic             issue_acc;

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            busy[n] = (cnt_q[n] != '0);
        end
    end

    assign err = err_q;

`ifdef SCOREBOARD_BYPASS_EN
    // A last pending write retiring this cycle frees the register for stall only.
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            stall_mask[n] = busy[n] &&
                            !((cnt_q[n] == ONE) && commit_valid && (commit_reg == 2'(n)) &&
                              !(kill_valid && (kill_reg == 2'(n))));
        end
    end
`else
    assign stall_mask = busy;
`endif

    assign stall     = (use_rs && stall_mask[rs_addr]) || (use_rt && stall_mask[rt_addr]);
    assign issue_acc = issue_valid && !stall;

    always_comb begin
        logic inc;
        logic dc;
        logic dk;
        err_d = err_q;
        inc   = 1'b0;
        dc    = 1'b0;
        dk    = 1'b0;
        for (int unsigned n = 0; n < 4; n++) begin
            cnt_d[n] = cnt_q[n];
            inc      = issue_acc && (issue_reg == 2'(n));
            dc       = commit_valid && (commit_reg == 2'(n));
            dk       = kill_valid && (kill_reg == 2'(n));
            // Net delta per register: +1, 0, -1 or -2, saturating with err.
            case ({inc, dc, dk})
                3'b100: begin
                    if (cnt_q[n] == CNT_MAX) err_d = 1'b1;
                    else                     cnt_d[n] = cnt_q[n] + ONE;
                end
                3'b000, 3'b110, 3'b101: ;
                3'b010, 3'b001, 3'b111: begin
                    if (cnt_q[n] == '0) err_d = 1'b1;
                    else                cnt_d[n] = cnt_q[n] - ONE;
                end
                default: begin
                    if ((cnt_q[n] == '0) || (cnt_q[n] == ONE)) begin
                        cnt_d[n] = '0;
                        err_d    = 1'b1;
                    end else begin
                        cnt_d[n] = cnt_q[n] - TWO;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized bench for reg_scoreboard against an arithmetic reference model.
module tb_reg_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid, commit_valid, kill_valid;
    logic [1:0] issue_reg, commit_reg, kill_reg;
    logic       use_rs, use_rt;
    logic [1:0] rs_addr, rt_addr;
    logic       stall;
    logic [3:0] busy;
    logic       err;

    int vectors    = 0;
    int miscompares = 0;

    int m_cnt [4];
    bit m_err;

    reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .commit_valid(commit_valid), .commit_reg(commit_reg),
        .kill_valid(kill_valid), .kill_reg(kill_reg),
        .use_rs(use_rs), .use_rt(use_rt),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .stall(stall), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_src_blocked(input int r);
        bit b;
        b = (m_cnt[r] != 0);
`ifdef SCOREBOARD_BYPASS_EN
        if (m_cnt[r] == 1 && commit_valid && int'(commit_reg) == r &&
            !(kill_valid && int'(kill_reg) == r))
            b = 0;
`endif
        return b;
    endfunction

    // Drive one cycle, check combinational outputs, clock it, update the model.
    task automatic step(input bit rst, input bit iv, input int ir,
                        input bit cv, input int cr, input bit kv, input int kr,
                        input bit urs, input int rs, input bit urt, input int rt);
        logic [3:0] exp_busy;
        bit         exp_stall;
        int         t;
        reset = rst; issue_valid = iv; issue_reg = 2'(ir);
        commit_valid = cv; commit_reg = 2'(cr); kill_valid = kv; kill_reg = 2'(kr);
        use_rs = urs; rs_addr = 2'(rs); use_rt = urt; rt_addr = 2'(rt);
        #1;
        for (int n = 0; n < 4; n++) exp_busy[n] = (m_cnt[n] != 0);
        exp_stall = (urs && m_src_blocked(rs)) || (urt && m_src_blocked(rt));
        chk("busy", busy, exp_busy);
        chk("err", {3'b0, err}, {3'b0, m_err});
        chk("stall", {3'b0, stall}, {3'b0, exp_stall});
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < 4; n++) m_cnt[n] = 0;
            m_err = 0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                t = m_cnt[n];
                if (iv && !exp_stall && ir == n) t++;
                if (cv && cr == n) t--;
                if (kv && kr == n) t--;
                if (t > MAXC) begin t = MAXC; m_err = 1; end
                if (t < 0)    begin t = 0;    m_err = 1; end
                m_cnt[n] = t;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic issue(input int r);
        step(0, 1, r, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic commit(input int r);
        step(0, 0, 0, 1, r, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; issue_valid = 0; issue_reg = 0; commit_valid = 0; commit_reg = 0;
        kill_valid = 0; kill_reg = 0; use_rs = 0; use_rt = 0; rs_addr = 0; rt_addr = 0;
        for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        m_err = 0;
        @(posedge clk); #1;

        // Reset state, stall clear even with sources in use
        step(1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 3);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 3);

        // Issue then dependent read
        do_reset();
        issue(2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

        // Commit with same-cycle reader (bypass-sensitive)
        do_reset();
        issue(1);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
        idle();

        // Issue and commit to same register cancel
        do_reset();
        issue(3);
        issue(3);
        step(0, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0);
        idle();

        // Overflow saturates, err sticky through commits
        do_reset();
        repeat (4) issue(0);
        repeat (3) commit(0);
        idle();

        // Underflow, then reset clears err
        do_reset();
        commit(2);
        idle();
        do_reset();
        idle();

        // Stalled issue is not accepted
        do_reset();
        issue(1);
        step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle();

        // Kill plus commit on a register holding one: underflow by two
        do_reset();
        issue(3);
        step(0, 0, 0, 1, 3, 1, 3, 0, 0, 0, 0);
        idle();

        // Late commits after mid-operation reset
        do_reset();
        issue(0); issue(1);
        do_reset();
        commit(1);
        idle();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < 60), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 35), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 10), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
